// File: rtl/xm_psw_pkg.sv
// Shared PSW layout, field positions and sequencer state encoding for the
// exception entry/return controller.
package xm_psw_pkg;

  localparam logic [15:0] VEC_BASE_DEFAULT = 16'hFFC0;

  typedef enum logic [2:0] {
    PSW_C   = 3'd0,
    PSW_Z   = 3'd1,
    PSW_N   = 3'd2,
    PSW_V   = 3'd3,
    PSW_SLP = 3'd4
  } psw_bit_e;

  localparam int CP_HI = 7;
  localparam int CP_LO = 5;
  localparam int PP_HI = 15;
  localparam int PP_LO = 13;

  typedef struct packed {
    logic [2:0] pp;
    logic [4:0] rsvd;
    logic [2:0] cp;
    logic       slp;
    logic       v;
    logic       n;
    logic       z;
    logic       c;
  } psw_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PUSH_PC,
    S_PUSH_PSW,
    S_RD_VPSW,
    S_RD_VPC,
    S_COMMIT,
    S_POP_PSW,
    S_POP_PC,
    S_RCOMMIT
  } seq_state_e;

  // Handler PSW: vector word with the new priority installed, the old one
  // saved in PP, and sleep cleared so the handler runs.
  function automatic psw_t entry_psw(input psw_t vec_psw, input logic [2:0] new_cp,
                                     input logic [2:0] old_cp);
    psw_t p;
    p = vec_psw;
    p[CP_HI:CP_LO] = new_cp;
    p[PP_HI:PP_LO] = old_cp;
    p[PSW_SLP] = 1'b0;
    return p;
  endfunction

endpackage

// File: rtl/exc_mem_port.sv
// Memory port for the exception sequencer: drives the bus from the FSM's
// registered request and captures read data when the access completes.
module exc_mem_port (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        done,
  output logic [15:0] rd_data
);

  // Request fields come from state and latched registers only, so they stay
  // put for as long as mem_ready is held low.
  assign mem_req   = req;
  assign mem_we    = req & we;
  assign mem_addr  = req ? addr : 16'h0000;
  assign mem_wdata = (req & we) ? wdata : 16'h0000;
  assign done      = req & mem_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= 16'h0000;
    end else if (done && !we) begin
      rd_data <= mem_rdata;
    end
  end

endmodule

// File: rtl/exception_sequencer.sv
// Sequences interrupt entry (stack PC/PSW, fetch vector, commit) and RETI
// (pop PSW/PC, commit) while stalling the control unit via busy.
module exception_sequencer
  import xm_psw_pkg::*;
#(
  parameter logic [15:0] VEC_BASE = VEC_BASE_DEFAULT,
  parameter int          VEC_W    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             irq_req,
  input  logic [VEC_W-1:0] irq_vec,
  input  logic [2:0]       irq_pri,
  output logic             irq_ack,
  input  logic             reti_req,
  input  logic [15:0]      psw_in,
  output logic [1:0]       psw_wr_en,
  output logic [15:0]      psw_wr_data,
  input  logic [15:0]      pc_in,
  output logic [15:0]      pc_out,
  output logic             pc_wr,
  input  logic [15:0]      sp_in,
  output logic [15:0]      sp_out,
  output logic             sp_wr,
  output logic             mem_req,
  output logic             mem_we,
  output logic [15:0]      mem_addr,
  output logic [15:0]      mem_wdata,
  input  logic [15:0]      mem_rdata,
  input  logic             mem_ready,
  output logic             busy
);

  seq_state_e       state, state_nxt;
  logic [VEC_W-1:0] vec_q;
  logic [2:0]       pri_q;
  logic [15:0]      pc_q, sp_q, hold_q;
  psw_t             psw_q;
  logic             req, we, done, accept;
  logic [15:0]      addr, wdata, rd_data, vec_addr;

  assign accept   = rst_n && irq_req && (irq_pri > psw_in[CP_HI:CP_LO]);
  assign vec_addr = VEC_BASE + {{(16-VEC_W-2){1'b0}}, vec_q, 2'b00};
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      vec_q  <= '0;
      pri_q  <= 3'd0;
      pc_q   <= 16'h0000;
      sp_q   <= 16'h0000;
      psw_q  <= '0;
      hold_q <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE) begin
        if (accept) begin
          vec_q <= irq_vec;
          pri_q <= irq_pri;
          pc_q  <= pc_in;
          psw_q <= psw_in;
          sp_q  <= sp_in;
        end else if (reti_req) begin
          sp_q <= sp_in;
        end
      end
      // First read of each sequence is parked here; the second stays in the port.
      if (done && (state == S_RD_VPSW || state == S_POP_PSW)) hold_q <= mem_rdata;
    end
  end

  always_comb begin
    state_nxt   = state;
    irq_ack     = 1'b0;
    req         = 1'b0;
    we          = 1'b0;
    addr        = 16'h0000;
    wdata       = 16'h0000;
    psw_wr_en   = 2'b00;
    psw_wr_data = 16'h0000;
    pc_out      = 16'h0000;
    pc_wr       = 1'b0;
    sp_out      = 16'h0000;
    sp_wr       = 1'b0;
    case (state)
      S_IDLE: begin
        // An accepted interrupt wins; a coincident RETI is re-issued later.
        if (accept) begin
          irq_ack   = 1'b1;
          state_nxt = S_PUSH_PC;
        end else if (reti_req) begin
          state_nxt = S_POP_PSW;
        end
      end
      S_PUSH_PC: begin
        req = 1'b1; we = 1'b1; addr = sp_q - 16'd2; wdata = pc_q;
        if (done) state_nxt = S_PUSH_PSW;
      end
      S_PUSH_PSW: begin
        req = 1'b1; we = 1'b1; addr = sp_q - 16'd4; wdata = psw_q;
        if (done) state_nxt = S_RD_VPSW;
      end
      S_RD_VPSW: begin
        req = 1'b1; addr = vec_addr;
        if (done) state_nxt = S_RD_VPC;
      end
      S_RD_VPC: begin
        req = 1'b1; addr = vec_addr + 16'd2;
        if (done) state_nxt = S_COMMIT;
      end
      S_COMMIT: begin
        psw_wr_en   = 2'b11;
        psw_wr_data = entry_psw(psw_t'(hold_q), pri_q, psw_q.cp);
        pc_out      = rd_data;
        pc_wr       = 1'b1;
        sp_out      = sp_q - 16'd4;
        sp_wr       = 1'b1;
        state_nxt   = S_IDLE;
      end
      S_POP_PSW: begin
        req = 1'b1; addr = sp_q;
        if (done) state_nxt = S_POP_PC;
      end
      S_POP_PC: begin
        req = 1'b1; addr = sp_q + 16'd2;
        if (done) state_nxt = S_RCOMMIT;
      end
      S_RCOMMIT: begin
        psw_wr_en   = 2'b11;
        psw_wr_data = hold_q;
        pc_out      = rd_data;
        pc_wr       = 1'b1;
        sp_out      = sp_q + 16'd4;
        sp_wr       = 1'b1;
        state_nxt   = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  exc_mem_port u_mem_port (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .done      (done),
    .rd_data   (rd_data)
  );

endmodule

// File: tb/tb_exception_sequencer.sv
// Bench for exception_sequencer: memory/CPU environment, reference model of
// entry/RETI, scoreboard queues for stack writes and commits.
module tb_exception_sequencer;

  localparam int W = 56;
  localparam logic [15:0] VB = 16'hFFC0;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        irq_req = 1'b0, reti_req = 1'b0;
  logic [2:0]  irq_vec = 3'd0, irq_pri = 3'd0;
  logic        irq_ack, pc_wr, sp_wr, mem_req, mem_we, mem_ready, busy;
  logic [1:0]  psw_wr_en;
  logic [15:0] psw_wr_data, pc_out, sp_out, mem_addr, mem_wdata, mem_rdata;

  // environment: CPU registers and memory
  logic [15:0] cpu_psw, cpu_pc, cpu_sp;
  logic        cpu_poke = 1'b0;
  logic [15:0] p_psw = 16'h0, p_pc = 16'h0, p_sp = 16'h0;
  logic [15:0] mem [0:32767];
  logic        mp_en = 1'b0;
  logic [15:0] mp_addr = 16'h0, mp_data = 16'h0;
  logic [3:0]  waits = 4'd0, wcnt = 4'd0;

  exception_sequencer dut (
    .clk(clk), .rst_n(rst_n), .irq_req(irq_req), .irq_vec(irq_vec), .irq_pri(irq_pri),
    .irq_ack(irq_ack), .reti_req(reti_req), .psw_in(cpu_psw), .psw_wr_en(psw_wr_en),
    .psw_wr_data(psw_wr_data), .pc_in(cpu_pc), .pc_out(pc_out), .pc_wr(pc_wr),
    .sp_in(cpu_sp), .sp_out(sp_out), .sp_wr(sp_wr), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .busy(busy)
  );

  assign mem_ready = mem_req && (wcnt >= waits);
  assign mem_rdata = mem[mem_addr[15:1]];

  always @(posedge clk) begin
    if (cpu_poke) begin
      cpu_psw <= p_psw; cpu_pc <= p_pc; cpu_sp <= p_sp;
    end else begin
      if (psw_wr_en[0]) cpu_psw[7:0]  <= psw_wr_data[7:0];
      if (psw_wr_en[1]) cpu_psw[15:8] <= psw_wr_data[15:8];
      if (pc_wr) cpu_pc <= pc_out;
      if (sp_wr) cpu_sp <= sp_out;
    end
    if (mp_en) mem[mp_addr[15:1]] <= mp_data;
    else if (mem_req && mem_we && mem_ready) mem[mem_addr[15:1]] <= mem_wdata;
    if (mem_req && !mem_ready) wcnt <= wcnt + 4'd1;
    else wcnt <= 4'd0;
  end

  // scoreboard
  logic [W-1:0]  exp_q[$];
  logic [31:0]   wq[$];
  int total = 0, bad = 0;
  int ack_seen = 0, exp_acks = 0;

  // reference model state
  logic [15:0] m_psw = 16'h0, m_pc = 16'h0, m_sp = 16'h0;
  logic [15:0] ref_mem [logic [15:0]];
  int depth = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // monitor
  int cyc = 0, start_cyc = 0;
  bit busy_d = 0, pend = 0;
  logic        h_we;
  logic [15:0] h_addr, h_wdata;
  logic [31:0] mw_e;
  logic [W-1:0] mc_e, mc_act;

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_d = 0;
      pend = 0;
    end else begin
      if (busy && !busy_d) start_cyc = cyc - 1;
      if (irq_ack) ack_seen++;
      if (pend && mem_req)
        chk({mem_we, mem_addr, mem_wdata} == {h_we, h_addr, h_wdata}, "mem_hold",
            {mem_we, mem_addr, mem_wdata}, {h_we, h_addr, h_wdata});
      pend = mem_req && !mem_ready;
      h_we = mem_we; h_addr = mem_addr; h_wdata = mem_wdata;
      if (mem_req && mem_we && mem_ready) begin
        if (wq.size() == 0) chk(1'b0, "unexp_write", {mem_addr, mem_wdata}, 64'h0);
        else begin
          mw_e = wq.pop_front();
          chk({mem_addr, mem_wdata} == mw_e, "stack_write", {mem_addr, mem_wdata}, mw_e);
        end
      end
      if (pc_wr || sp_wr || psw_wr_en != 2'b00) begin
        chk(pc_wr && sp_wr && psw_wr_en == 2'b11, "commit_strobes",
            {pc_wr, sp_wr, psw_wr_en}, 4'hF);
        if (exp_q.size() == 0) chk(1'b0, "unexp_commit", {psw_wr_data, pc_out, sp_out}, 64'h0);
        else begin
          mc_e = exp_q.pop_front();
          mc_act = {8'(cyc - start_cyc), psw_wr_data, pc_out, sp_out};
          chk(mc_act == mc_e, "commit", mc_act, mc_e);
        end
      end
      busy_d = busy;
    end
    cyc++;
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [15:0] mref(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
  endfunction

  function automatic logic [15:0] env_rd(input logic [15:0] a);
    return mem[a[15:1]];
  endfunction

  task automatic set_cpu(input logic [15:0] psw, input logic [15:0] pc, input logic [15:0] sp);
    p_psw = psw; p_pc = pc; p_sp = sp; cpu_poke = 1'b1;
    step();
    cpu_poke = 1'b0;
    m_psw = psw; m_pc = pc; m_sp = sp;
  endtask

  task automatic poke_mem(input logic [15:0] a, input logic [15:0] d);
    mp_en = 1'b1; mp_addr = a; mp_data = d;
    step();
    mp_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin
      step();
      n++;
    end
    chk(!busy, "idle_timeout", {63'h0, busy}, 64'h0);
  endtask

  // Model of entry: stack PC/PSW below SP, read vector pair, install priorities.
  task automatic model_entry(input logic [2:0] vec, input logic [2:0] pri);
    logic [15:0] sp2, sp4, va, vpsw, vpc, npsw;
    logic [7:0]  lat;
    sp2 = m_sp - 16'd2;
    sp4 = m_sp - 16'd4;
    wq.push_back({sp2, m_pc});
    wq.push_back({sp4, m_psw});
    ref_mem[sp2] = m_pc;
    ref_mem[sp4] = m_psw;
    va   = VB + 16'(vec) * 16'd4;
    vpsw = mref(va);
    vpc  = mref(va + 16'd2);
    npsw = (vpsw & 16'h1F0F) | (16'(m_psw[7:5]) << 13) | (16'(pri) << 5);
    lat  = 8'(5 + 4 * int'(waits));
    exp_q.push_back({lat, npsw, vpc, sp4});
    m_psw = npsw; m_pc = vpc; m_sp = sp4;
    depth++;
    exp_acks++;
  endtask

  task automatic model_reti();
    logic [15:0] p, c;
    logic [7:0]  lat;
    p = mref(m_sp);
    c = mref(m_sp + 16'd2);
    lat = 8'(3 + 2 * int'(waits));
    exp_q.push_back({lat, p, c, m_sp + 16'd4});
    m_psw = p; m_pc = c; m_sp = m_sp + 16'd4;
    depth--;
  endtask

  task automatic issue(input bit irq, input logic [2:0] vec, input logic [2:0] pri, input bit reti);
    bit acc, do_reti;
    wait_idle();
    acc = irq && (pri > m_psw[7:5]);
    do_reti = reti && !acc;
    if (acc) model_entry(vec, pri);
    else if (do_reti) model_reti();
    irq_req = irq; irq_vec = vec; irq_pri = pri; reti_req = reti;
    step();
    irq_req = 1'b0; reti_req = 1'b0;
    chk(busy == (acc || do_reti), "busy_start", {63'h0, busy}, {63'h0, acc || do_reti});
    wait_idle();
    chk(ack_seen == exp_acks, "ack_count", 64'(ack_seen), 64'(exp_acks));
  endtask

  task automatic chk_cpu(input string name, input logic [15:0] psw, input logic [15:0] pc,
                         input logic [15:0] sp);
    chk({cpu_psw, cpu_pc, cpu_sp} == {psw, pc, sp}, name, {cpu_psw, cpu_pc, cpu_sp}, {psw, pc, sp});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    cpu_poke = 1'b1;
    repeat (3) step();
    cpu_poke = 1'b0;
    rst_n = 1'b1;
    step();
    chk({busy, irq_ack, pc_wr, sp_wr, psw_wr_en, mem_req, mem_we} == 8'h00, "reset_ctrl",
        {busy, irq_ack, pc_wr, sp_wr, psw_wr_en, mem_req, mem_we}, 64'h0);
    chk({psw_wr_data, pc_out, sp_out, mem_addr} == 64'h0, "reset_data",
        {psw_wr_data, pc_out, sp_out, mem_addr}, 64'h0);

    for (int v = 0; v < 8; v++) begin
      r = $urandom;
      poke_mem(VB + 16'(v * 4),     (v == 3) ? 16'h0003 : r[15:0]);
      poke_mem(VB + 16'(v * 4 + 2), (v == 3) ? 16'h4000 : r[31:16]);
    end

    // zero-wait entry
    waits = 4'd0;
    set_cpu(16'h0045, 16'h1234, 16'h0800);
    issue(1'b1, 3'd3, 3'd5, 1'b0);
    chk_cpu("entry_regs", 16'h40A3, 16'h4000, 16'h07FC);
    chk({env_rd(16'h07FE), env_rd(16'h07FC)} == 32'h1234_0045, "entry_stack",
        {env_rd(16'h07FE), env_rd(16'h07FC)}, 32'h1234_0045);

    // priority rejection, then a strictly higher priority
    set_cpu(16'h00A0, 16'h1000, 16'h0800);
    issue(1'b1, 3'd2, 3'd5, 1'b0);
    repeat (3) step();
    chk(!busy, "reject_idle", {63'h0, busy}, 64'h0);
    issue(1'b1, 3'd2, 3'd6, 1'b0);

    // RETI
    poke_mem(16'h07FC, 16'h0045);
    poke_mem(16'h07FE, 16'h1234);
    set_cpu(16'h40A3, 16'h4000, 16'h07FC);
    depth = 1;
    issue(1'b0, 3'd0, 3'd0, 1'b1);
    chk_cpu("reti_regs", 16'h0045, 16'h1234, 16'h0800);

    // wait states
    waits = 4'd3;
    set_cpu(16'h0045, 16'h1234, 16'h0800);
    issue(1'b1, 3'd3, 3'd5, 1'b0);
    chk_cpu("wait_regs", 16'h40A3, 16'h4000, 16'h07FC);
    waits = 4'd0;

    // simultaneous irq and RETI
    set_cpu(16'h0045, 16'h1234, 16'h0800);
    issue(1'b1, 3'd3, 3'd5, 1'b1);
    chk_cpu("simul_regs", 16'h40A3, 16'h4000, 16'h07FC);

    // SP wrap
    set_cpu(16'h0045, 16'h1234, 16'h0002);
    issue(1'b1, 3'd3, 3'd5, 1'b0);
    chk_cpu("wrap_regs", 16'h40A3, 16'h4000, 16'hFFFE);
    chk({env_rd(16'h0000), env_rd(16'hFFFE)} == 32'h1234_0045, "wrap_stack",
        {env_rd(16'h0000), env_rd(16'hFFFE)}, 32'h1234_0045);

    // nested: higher priority taken in the IDLE cycle after commit
    set_cpu(16'h0045, 16'h1234, 16'h0800);
    issue(1'b1, 3'd3, 3'd5, 1'b0);
    issue(1'b1, 3'd1, 3'd7, 1'b0);

    // reset while reading the vector PC
    set_cpu(16'h0045, 16'h1234, 16'h0800);
    wait_idle();
    wq.push_back({16'h07FE, 16'h1234});
    wq.push_back({16'h07FC, 16'h0045});
    ref_mem[16'h07FE] = 16'h1234;
    ref_mem[16'h07FC] = 16'h0045;
    exp_acks++;
    irq_req = 1'b1; irq_vec = 3'd3; irq_pri = 3'd5;
    step();
    irq_req = 1'b0;
    repeat (3) step();
    chk(mem_req && !mem_we && mem_addr == 16'hFFCE, "rd_vpc_addr",
        {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 16'hFFCE});
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk({busy, pc_wr, sp_wr, psw_wr_en} == 5'b0, "abort_idle",
        {busy, pc_wr, sp_wr, psw_wr_en}, 64'h0);
    repeat (10) step();
    chk_cpu("abort_regs", 16'h0045, 16'h1234, 16'h0800);
    chk(ack_seen == exp_acks, "abort_ack", 64'(ack_seen), 64'(exp_acks));

    // randomized nesting / returns
    set_cpu(16'h0005, 16'h2000, 16'h4000);
    depth = 0;
    for (int i = 0; i < 40; i++) begin
      waits = 4'($urandom_range(0, 2));
      r = $urandom;
      set_cpu({m_psw[15:4], r[3:0]}, r[31:16], m_sp);
      if (depth > 0 && $urandom_range(0, 2) == 0)
        issue(1'b0, 3'd0, 3'd0, 1'b1);
      else
        issue(1'b1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              (depth > 0) && ($urandom_range(0, 3) == 0));
    end

    repeat (5) step();
    chk(exp_q.size() == 0, "commits_left", 64'(exp_q.size()), 64'h0);
    chk(wq.size() == 0, "writes_left", 64'(wq.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exception_sequencer.md
Name: exception_sequencer

Overview:
- Multi-cycle controller that sequences exception entry and return (RETI) around the program status register.
- On an accepted interrupt it stacks PC and PSW, loads a new PSW/PC pair from the vector table and updates priority fields. On RETI it restores both from the stack.
- Owns the PSW byte-write port (wr_en/wr_data) while active, and stalls the main control unit for the duration.

Parameters:
- VEC_BASE, 16'hFFC0, byte address of the vector table; entry n is at VEC_BASE + 4*n, holding a PSW word then a PC word.
- VEC_W, 3, width of the vector index (8 vectors).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- irq_req  in  1  pending interrupt (level)
- irq_vec  in  VEC_W  vector index of the pending interrupt
- irq_pri  in  3  priority of the pending interrupt
- irq_ack  out  1  one-cycle pulse when the interrupt is accepted
- reti_req  in  1  one-cycle pulse from the control unit at RETI execute
- psw_in  in  16  current PSW
- psw_wr_en  out  2  byte enables to the PSW register
- psw_wr_data  out  16  PSW write data
- pc_in  in  16  current PC (return address)
- pc_out  out  16  new PC value
- pc_wr  out  1  PC load strobe
- sp_in  in  16  current stack pointer
- sp_out  out  16  new SP value
- sp_wr  out  1  SP load strobe
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write
- mem_addr  out  16  word-aligned byte address
- mem_wdata  out  16  write data
- mem_rdata  in  16  read data, valid with mem_ready
- mem_ready  in  1  access complete
- busy  out  1  sequencer active; the control unit stalls

Behaviour:
- Reset (rst_n = 0 at a clk edge): state IDLE. All strobes, mem_req, irq_ack, psw_wr_en and busy are 0; all data outputs are 0; internal latches are cleared.
- PSW layout: [0] C, [1] Z, [2] N, [3] V, [4] SLP, [7:5] current priority (CP), [15:13] previous priority (PP).
- IDLE accept rule: an interrupt is accepted when irq_req = 1 and irq_pri > CP (strictly greater).
  - An accepted interrupt takes precedence over reti_req in the same cycle; that RETI is dropped, because the control unit re-issues it after the stall.
  - On accept: irq_ack pulses for 1 cycle; irq_vec, irq_pri, pc_in, psw_in and sp_in are latched.
- Entry sequence, one memory access per state; each state holds mem_req and its address/data stable until mem_ready:
  - PUSH_PC: write PC to SP-2.
  - PUSH_PSW: write PSW to SP-4.
  - RD_VPSW: read VEC_BASE + 4*vec into vpsw.
  - RD_VPC: read VEC_BASE + 4*vec + 2 into vpc.
  - COMMIT (1 cycle, no memory access):
    - psw_wr_en = 2'b11.
    - psw_wr_data = vpsw with [7:5] = latched irq_pri, [15:13] = old CP, [4] = 0.
    - pc_out = vpc, pc_wr = 1; sp_out = SP-4, sp_wr = 1.
    - Next state is IDLE.
- Return sequence, triggered by reti_req in IDLE when no interrupt is accepted:
  - POP_PSW: read SP.
  - POP_PC: read SP+2.
  - RCOMMIT: psw_wr_en = 2'b11, psw_wr_data = popped PSW; pc_out = popped PC, pc_wr = 1; sp_out = SP+4, sp_wr = 1; next state IDLE.
- Timing and strobes:
  - busy = 1 in every non-IDLE state.
  - Minimum latency with zero-wait memory: entry 5 cycles, return 3 cycles from accept to commit.
  - pc_wr, sp_wr and psw_wr_en are single-cycle and asserted only in COMMIT/RCOMMIT.
- Nesting: interrupts are not sampled while busy. A higher-priority interrupt is accepted in the IDLE cycle following COMMIT, because the new CP is then visible on psw_in.
- Address arithmetic is 16-bit modulo. SP-4 at SP = 16'h0002 wraps to 16'hFFFE without error.
- mem_ready held low stalls the current state indefinitely. mem_ready asserted in IDLE is ignored.
- Reset mid-sequence aborts the sequence: no commit strobe fires, and partial stack writes are not undone.

Decomposition:
- Shared package xm_psw_pkg:
  - PSW bit-index enum (C, Z, N, V, SLP) and CP/PP field ranges.
  - Packed psw_t struct.
  - Sequencer state enum.
  - VEC_BASE default.
- Optional sub-module exc_mem_port: holds mem_req/addr/data stable and captures mem_rdata on mem_ready. All other logic stays in the main FSM.

Test Plan:
- Entry with zero-wait memory:
  - Setup: CP = 2, irq_req = 1, irq_pri = 5, irq_vec = 3, SP = 16'h0800, PC = 16'h1234, PSW = 16'h0045; memory[FFCC] = 16'h0003, memory[FFCE] = 16'h4000.
  - Required: mem[07FE] = 1234 and mem[07FC] = 0045; commit writes PSW = 16'h40A3, PC = 4000, SP = 07FC; irq_ack pulses exactly once.
- Priority rejection: CP = 5, irq_pri = 5 -> no irq_ack, busy stays 0. Raise irq_pri to 6 -> accepted.
- RETI:
  - Setup: SP = 07FC, memory holds 0045 / 1234.
  - Required: PSW = 0045, PC = 1234, SP = 0800 after 3 cycles.
- Wait states: mem_ready low for 3 cycles on each access -> mem_addr/mem_wdata stable throughout; commit delayed by 12 cycles; final values identical to the zero-wait entry case.
- Simultaneous and wrap cases:
  - irq_req and reti_req in the same cycle -> the entry sequence runs and the RETI is dropped.
  - SP = 0002 -> pushes go to 0000 and FFFE; SP becomes FFFE.
- Reset during RD_VPC (rst_n = 0 for 1 cycle) -> IDLE next cycle; pc_wr, sp_wr and psw_wr_en never assert; busy = 0.
